// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encodings for the "110" Moore/Mealy detectors
package seq_det_pkg;
    typedef logic [1:0] state_t;
    localparam logic [1:0] M_S0   = 2'b00;
    localparam logic [1:0] M_S1   = 2'b01;
    localparam logic [1:0] M_S11  = 2'b10;
    localparam logic [1:0] M_S110 = 2'b11;
    localparam logic [1:0] E_S0   = 2'b00;
    localparam logic [1:0] E_S1   = 2'b01;
    localparam logic [1:0] E_S11  = 2'b10;
    localparam logic [2:0] PATTERN = 3'b110;
endpackage

// File: rtl/seq_det_mealy_fsm.sv
// seq_det_mealy_fsm: Mealy "110" detector; SEQ_DET_MEALY_REG_EN registers out_me
module seq_det_mealy_fsm
    import seq_det_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out_me,
    output state_t     cstate1,
    output state_t     nstate1
);
    logic det;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cstate1 <= E_S0;
        else      cstate1 <= nstate1;
    end
    always_comb begin
        case (cstate1)
            E_S0:    nstate1 = in ? E_S1  : E_S0;
            E_S1:    nstate1 = in ? E_S11 : E_S0;
            E_S11:   nstate1 = in ? E_S11 : E_S0;
            default: nstate1 = E_S0;
        endcase
    end
    assign det = (cstate1 == E_S11) && !in;
`ifdef SEQ_DET_MEALY_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_me <= 1'b0;
        else      out_me <= det;
    end
`else
    assign out_me = det;
`endif
endmodule

// File: rtl/seq_detector_110.sv
// seq_detector_110: parallel Moore/Mealy overlapping "110" detectors (SEQ_DET_MEALY_REG_EN registers out_me)
module seq_detector_110
    import seq_det_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out_mo,
    output logic       out_me,
    output state_t     cstate,
    output state_t     nstate,
    output state_t     cstate1,
    output state_t     nstate1
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cstate <= M_S0;
        else      cstate <= nstate;
    end
    always_comb begin
        case (cstate)
            M_S0:    nstate = in ? M_S1  : M_S0;
            M_S1:    nstate = in ? M_S11 : M_S0;
            M_S11:   nstate = in ? M_S11 : M_S110;
            M_S110:  nstate = in ? M_S1  : M_S0;
            default: nstate = M_S0;
        endcase
    end
    assign out_mo = cstate == M_S110;
    seq_det_mealy_fsm u_mealy (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .out_me  (out_me),
        .cstate1 (cstate1),
        .nstate1 (nstate1)
    );
endmodule

// File: tb/tb_seq_detector_110.sv
// tb_seq_detector_110: directed streams checked against a bit-history model via a scoreboard queue
module tb_seq_detector_110;
`ifdef SEQ_DET_MEALY_REG_EN
    localparam bit REG_ME = 1'b1;
`else
    localparam bit REG_ME = 1'b0;
`endif
    typedef struct packed {
        logic       mo;
        logic [1:0] cs;
        logic [1:0] cs1;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in  = 1'b0;
    logic       out_mo, out_me;
    logic [1:0] cstate, nstate, cstate1, nstate1;
    int         checks = 0;
    int         errors = 0;
    int         k = 0;
    logic [2:0] hist = 3'b000;
    exp_t       q[$];
    int         mo_t[$];
    int         me_t[$];

    seq_detector_110 dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .out_mo  (out_mo),
        .out_me  (out_me),
        .cstate  (cstate),
        .nstate  (nstate),
        .cstate1 (cstate1),
        .nstate1 (nstate1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [1:0] m_state(logic [2:0] h);
        return h == 3'b110 ? 2'b11 : h[1:0] == 2'b11 ? 2'b10 : h[0] ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [1:0] e_state(logic [2:0] h);
        return h[1:0] == 2'b11 ? 2'b10 : h[0] ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step(input logic b);
        exp_t       e;
        logic [2:0] nh;
        logic       me_exp;
        @(negedge clk);
        in = b;
        #1;
        nh     = {hist[1:0], b};
        me_exp = REG_ME ? (hist == 3'b110) : (e_state(hist) == 2'b10 && !b);
        chk("out_me", out_me, me_exp);
        chk("nstate", nstate, m_state(nh));
        chk("nstate1", nstate1, e_state(nh));
        if (out_me) me_t.push_back(k);
        e.mo  = nh == 3'b110;
        e.cs  = m_state(nh);
        e.cs1 = e_state(nh);
        q.push_back(e);
        hist = nh;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("out_mo", out_mo, e.mo);
        chk("cstate", cstate, e.cs);
        chk("cstate1", cstate1, e.cs1);
        if (out_mo) mo_t.push_back(k + 1);
        k++;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        hist = 3'b000;
        #1;
        chk("rst_cstate", cstate, 2'b00);
        chk("rst_cstate1", cstate1, 2'b00);
        chk("rst_out_mo", out_mo, 1'b0);
        chk("rst_out_me", out_me, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in = i[0];
            #1;
            chk("rst_hold_cstate", cstate, 2'b00);
            chk("rst_hold_cstate1", cstate1, 2'b00);
            chk("rst_out_mo", out_mo, 1'b0);
            chk("rst_out_me", out_me, 1'b0);
            chk("rst_nstate", nstate, i[0] ? 2'b01 : 2'b00);
            chk("rst_nstate1", nstate1, i[0] ? 2'b01 : 2'b00);
        end
        @(negedge clk);
        rst = 1'b1;
        in  = 1'b0;
    endtask

    initial begin
        async_reset();
        foreach (q[i]) chk("queue_empty", 1, 0);
        step(1); step(1); step(0); step(0);
        mo_t.delete();
        me_t.delete();
        step(1); step(1); step(0); step(1); step(1); step(0); step(0); step(0);
        chk("mo_pulses", mo_t.size(), 2);
        chk("me_pulses", me_t.size(), 2);
        if (mo_t.size() == 2 && me_t.size() == 2) begin
            chk("mo_spacing", mo_t[1] - mo_t[0], 3);
            chk("me_spacing", me_t[1] - me_t[0], 3);
            chk("me_lead0", mo_t[0] - me_t[0], REG_ME ? 0 : 1);
            chk("me_lead1", mo_t[1] - me_t[1], REG_ME ? 0 : 1);
        end
        mo_t.delete();
        step(0); step(1); step(1); step(1); step(1); step(0); step(0);
        chk("run_ones_pulses", mo_t.size(), 1);
        mo_t.delete();
        me_t.delete();
        step(1); step(0); step(1); step(0); step(0);
        chk("no_det_mo", mo_t.size(), 0);
        chk("no_det_me", me_t.size(), 0);
        chk("no_det_cstate", cstate, 2'b00);
        chk("no_det_cstate1", cstate1, 2'b00);
        step(1); step(1);
        chk("pre_abort_cstate", cstate, 2'b10);
        async_reset();
        mo_t.delete();
        me_t.delete();
        step(0); step(0); step(0);
        chk("abort_mo", mo_t.size(), 0);
        chk("abort_me", me_t.size(), 0);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
